// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and default bit timing,
// common to the receiver and the future transmitter.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 217;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Serial-receive bundle: line input plus received byte and status strobes.
interface uart_rx_if;
    import uart_pkg::*;

    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_frame_err;
    logic       RxD_busy;

    modport master (
        output RxD,
        input  RxD_data,
        input  RxD_data_ready,
        input  RxD_frame_err,
        input  RxD_busy
    );

    modport slave (
        input  RxD,
        output RxD_data,
        output RxD_data_ready,
        output RxD_frame_err,
        output RxD_busy
    );

endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, glitch reject, frame error strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave rx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    uart_state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] shreg;
    logic [7:0] data_q;
    logic rxd_s;
    logic prev;
    logic ready_q;
    logic err_q;
    logic busy_q;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx.RxD),
        .q     (rxd_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            data_q  <= '0;
            prev    <= 1'b1;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            prev    <= rxd_s;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Only a real 1->0 edge starts a frame; a stuck-low line never does
                    if (prev && !rxd_s) begin
                        state  <= START;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        idx <= '0;
                        if (!rxd_s) begin
                            state <= DATA;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rxd_s, shreg[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt    <= '0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        if (rxd_s) begin
                            data_q  <= shreg;
                            ready_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx.RxD_data       = data_q;
    assign rx.RxD_data_ready = ready_q;
    assign rx.RxD_frame_err  = err_q;
    assign rx.RxD_busy       = busy_q;

endmodule
